// File: rtl/servo_move_scheduler.sv
// rtl/servo_move_scheduler.sv - queues low/high servo moves and times target/neutral duty for the PWM driver
module servo_move_scheduler #(
    parameter logic [9:0] NEUTRAL_DUTY  = 10'd77,
    parameter logic [9:0] LOW_DUTY      = 10'd51,
    parameter logic [9:0] HIGH_DUTY     = 10'd92,
    parameter int         HOLD_CYCLES   = 12500000,
    parameter int         SETTLE_CYCLES = 2500000,
    parameter int         CNT_W         = 24
) (
    input  logic       clk25mhz,
    input  logic       reset,
    input  logic       cmd_valid,
    input  logic [1:0] cmd_dir,
    output logic       cmd_ready,
    input  logic       abort,
    output logic [9:0] duty_cycle_output,
    output logic       busy,
    output logic       move_done,
    output logic       cmd_error
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MOVE,
        ST_SETTLE
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [9:0]       duty_q, duty_d;
    logic             head_q, head_d;
    logic             tail_q, tail_d;
    logic [1:0]       count_q, count_d;
    logic             move_done_q, move_done_d;
    logic             cmd_error_q, cmd_error_d;

    logic             cmd_legal;
    logic             transfer;
    logic             push;
    logic             pop;

    // Queue entries hold one bit: 1 = high move, 0 = low move.
    assign cmd_legal = (cmd_dir == 2'b01) || (cmd_dir == 2'b10);
    assign cmd_ready = !reset && (count_q != 2'd2) && !abort;
    assign transfer  = cmd_valid && cmd_ready;
    assign push      = transfer && cmd_legal;

    assign duty_cycle_output = duty_q;
    assign busy              = (state_q != ST_IDLE) || (count_q != 2'd0);
    assign move_done         = move_done_q;
    assign cmd_error         = cmd_error_q;

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        duty_d      = duty_q;
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        move_done_d = 1'b0;
        cmd_error_d = transfer && !cmd_legal;
        pop         = 1'b0;

        if (abort) begin
            count_d = 2'd0;
            duty_d  = NEUTRAL_DUTY;
            timer_d = SETTLE_LOAD;
            state_d = ST_SETTLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (count_q != 2'd0) begin
                        pop     = 1'b1;
                        duty_d  = head_q ? HIGH_DUTY : LOW_DUTY;
                        timer_d = HOLD_LOAD;
                        state_d = ST_MOVE;
                    end else begin
                        duty_d = NEUTRAL_DUTY;
                    end
                end
                ST_MOVE: begin
                    if (timer_q != '0) begin
                        timer_d = timer_q - CNT_W'(1);
                    end else begin
                        duty_d  = NEUTRAL_DUTY;
                        timer_d = SETTLE_LOAD;
                        state_d = ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (timer_q != '0) begin
                        timer_d = timer_q - CNT_W'(1);
                    end else begin
                        move_done_d = 1'b1;
                        state_d     = ST_IDLE;
                    end
                end
                default: begin
                    duty_d  = NEUTRAL_DUTY;
                    state_d = ST_IDLE;
                end
            endcase

            // Push never coincides with a full queue, so push+pop implies exactly one entry.
            case ({push, pop})
                2'b11: head_d = cmd_dir[1];
                2'b10: begin
                    if (count_q == 2'd0) begin
                        head_d = cmd_dir[1];
                    end else begin
                        tail_d = cmd_dir[1];
                    end
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    head_d  = tail_q;
                    count_d = count_q - 2'd1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk25mhz or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            duty_q      <= NEUTRAL_DUTY;
            head_q      <= 1'b0;
            tail_q      <= 1'b0;
            count_q     <= 2'd0;
            move_done_q <= 1'b0;
            cmd_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            duty_q      <= duty_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            move_done_q <= move_done_d;
            cmd_error_q <= cmd_error_d;
        end
    end

endmodule

// File: tb/tb_servo_move_scheduler.sv
// tb/tb_servo_move_scheduler.sv - self-checking bench for servo_move_scheduler
module tb_servo_move_scheduler;

    localparam int HOLD   = 10;
    localparam int SETTLE = 4;
    localparam int NEUT   = 77;
    localparam int LOWD   = 51;
    localparam int HIGHD  = 92;

    logic       clk;
    logic       reset;
    logic       cmd_valid;
    logic [1:0] cmd_dir;
    logic       cmd_ready;
    logic       abort;
    logic [9:0] duty;
    logic       busy;
    logic       move_done;
    logic       cmd_error;

    servo_move_scheduler #(
        .NEUTRAL_DUTY (10'd77),
        .LOW_DUTY     (10'd51),
        .HIGH_DUTY    (10'd92),
        .HOLD_CYCLES  (HOLD),
        .SETTLE_CYCLES(SETTLE),
        .CNT_W        (8)
    ) dut (
        .clk25mhz         (clk),
        .reset            (reset),
        .cmd_valid        (cmd_valid),
        .cmd_dir          (cmd_dir),
        .cmd_ready        (cmd_ready),
        .abort            (abort),
        .duty_cycle_output(duty),
        .busy             (busy),
        .move_done        (move_done),
        .cmd_error        (cmd_error)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Timeline model: each accepted move owns an interval of edge indices.
    int mq[$];
    int m_t;
    int m_active;
    int m_tgt;
    int m_tgt_end;
    int m_done_edge;
    int m_was;
    int m_ready;
    int m_xfer;
    int m_legal;
    int exp_duty;
    int exp_busy;
    int exp_done;
    int exp_err;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq.delete();
            m_t       = 0;
            m_active  = 0;
            m_tgt     = NEUT;
            m_tgt_end = -1;
            exp_duty  = NEUT;
            exp_busy  = 0;
            exp_done  = 0;
            exp_err   = 0;
        end else begin
            m_ready  = (mq.size() < 2 && !abort) ? 1 : 0;
            m_xfer   = (cmd_valid && m_ready != 0) ? 1 : 0;
            m_legal  = (cmd_dir == 2'd1 || cmd_dir == 2'd2) ? 1 : 0;
            exp_err  = (m_xfer != 0 && m_legal == 0) ? 1 : 0;
            exp_done = 0;
            if (abort) begin
                mq.delete();
                m_active    = 1;
                m_tgt_end   = m_t - 1;
                m_done_edge = m_t + SETTLE;
            end else begin
                m_was = m_active;
                if (m_active != 0 && m_t == m_done_edge) begin
                    exp_done = 1;
                    m_active = 0;
                end
                if (m_was == 0 && mq.size() > 0) begin
                    m_tgt       = (mq.pop_front() != 0) ? HIGHD : LOWD;
                    m_tgt_end   = m_t + HOLD - 1;
                    m_done_edge = m_t + HOLD + SETTLE;
                    m_active    = 1;
                end
                if (m_xfer != 0 && m_legal != 0) mq.push_back(cmd_dir == 2'd2 ? 1 : 0);
            end
            exp_duty = (m_active != 0 && m_t <= m_tgt_end) ? m_tgt : NEUT;
            exp_busy = (m_active != 0 || mq.size() > 0) ? 1 : 0;
            m_t++;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    int e = 0;
    int n_done = 0;

    task automatic tick();
        @(posedge clk);
        #2;
        e++;
        if (move_done === 1'b1) n_done++;
        chk("duty", int'(duty), exp_duty);
        chk("busy", int'(busy), exp_busy);
        chk("move_done", int'(move_done), exp_done);
        chk("cmd_error", int'(cmd_error), exp_err);
        chk("cmd_ready", int'(cmd_ready), (!reset && mq.size() < 2 && !abort) ? 1 : 0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    int e0;
    int d0;

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_dir   = 2'b00;
        abort     = 1'b0;

        // 1: reset and idle
        #1;
        chk("reset_duty", int'(duty), NEUT);
        chk("reset_ready", int'(cmd_ready), 0);
        ticks(2);
        reset = 1'b0;
        #1;
        chk("ready_after_release", int'(cmd_ready), 1);
        ticks(3);
        chk("idle_duty", int'(duty), NEUT);
        chk("idle_busy", int'(busy), 0);

        // 2: single low move
        cmd_valid = 1'b1;
        cmd_dir   = 2'b01;
        tick();
        cmd_valid = 1'b0;
        e0 = e;
        d0 = n_done;
        tick();
        chk("low_first", int'(duty), LOWD);
        ticks(9);
        chk("low_last", int'(duty), LOWD);
        tick();
        chk("low_back_neutral", int'(duty), NEUT);
        ticks(3);
        chk("low_no_done_early", int'(move_done), 0);
        tick();
        chk("low_done_n15", int'(move_done), 1);
        chk("low_busy_fall", int'(busy), 0);
        ticks(3);
        chk("low_one_done", n_done - d0, 1);

        // 3: three back-to-back commands
        cmd_valid = 1'b1;
        cmd_dir   = 2'b10;
        tick();
        e0 = e;
        d0 = n_done;
        cmd_dir = 2'b01;
        tick();
        cmd_dir = 2'b10;
        tick();
        cmd_valid = 1'b0;
        chk("full_not_ready", int'(cmd_ready), 0);
        for (int i = 0; i < 48; i++) begin
            tick();
            if (e == e0 + 10) chk("seq_92_last", int'(duty), HIGHD);
            if (e == e0 + 15) chk("seq_gap", int'(duty), NEUT);
            if (e == e0 + 16) chk("seq_51_first", int'(duty), LOWD);
            if (e == e0 + 31) chk("seq_92_again", int'(duty), HIGHD);
            if (e == e0 + 45) chk("seq_last_done", int'(move_done), 1);
        end
        chk("seq_three_dones", n_done - d0, 3);

        // 4: illegal codes
        cmd_valid = 1'b1;
        cmd_dir   = 2'b00;
        tick();
        chk("err_00", int'(cmd_error), 1);
        cmd_dir = 2'b11;
        tick();
        chk("err_11", int'(cmd_error), 1);
        cmd_valid = 1'b0;
        tick();
        chk("err_clear", int'(cmd_error), 0);
        chk("err_busy", int'(busy), 0);
        chk("err_duty", int'(duty), NEUT);
        ticks(2);

        // 5: abort during a high hold with one queued entry
        cmd_valid = 1'b1;
        cmd_dir   = 2'b10;
        tick();
        e0 = e;
        cmd_dir = 2'b01;
        tick();
        cmd_valid = 1'b0;
        ticks(2);
        chk("pre_abort_duty", int'(duty), HIGHD);
        d0 = n_done;
        abort = 1'b1;
        #1;
        chk("abort_not_ready", int'(cmd_ready), 0);
        tick();
        abort = 1'b0;
        chk("abort_duty", int'(duty), NEUT);
        ticks(3);
        chk("abort_no_done_early", int'(move_done), 0);
        tick();
        chk("abort_done", int'(move_done), 1);
        ticks(15);
        chk("abort_single_done", n_done - d0, 1);
        chk("abort_idle", int'(busy), 0);

        // 5b: abort held two cycles in idle still settles
        d0 = n_done;
        abort = 1'b1;
        ticks(2);
        abort = 1'b0;
        ticks(3);
        chk("idle_abort_wait", n_done - d0, 0);
        tick();
        chk("idle_abort_done", int'(move_done), 1);
        ticks(2);

        // 6: asynchronous reset mid-move
        cmd_valid = 1'b1;
        cmd_dir   = 2'b01;
        tick();
        cmd_valid = 1'b0;
        ticks(3);
        d0 = n_done;
        #5;
        reset = 1'b1;
        #1;
        chk("async_duty", int'(duty), NEUT);
        chk("async_busy", int'(busy), 0);
        chk("async_ready", int'(cmd_ready), 0);
        ticks(2);
        reset = 1'b0;
        ticks(20);
        chk("async_no_done", n_done - d0, 0);
        cmd_valid = 1'b1;
        cmd_dir   = 2'b10;
        tick();
        cmd_valid = 1'b0;
        tick();
        chk("resume_high", int'(duty), HIGHD);
        ticks(16);
        chk("resume_done", n_done - d0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
